// File: rtl/npu_simple_core.sv
// npu_simple_core: single-tile CNN compute block.
// Holds an 8-row byte buffer (activations, per-row 3x3 weight blocks and a
// 16-bit bias per row) and runs 8 parallel 9-tap MAC PEs followed by a
// shift / saturate / ReLU / 2:1 max-pool post stage.
// Pipeline: read register -> accumulator register -> output register.
// Optional feature macro: NPU_SIMPLE_MAXPOOL_EN (builds the max-pool logic;
// without it en_mp is ignored).
module npu_simple_core #(
  parameter int width    = 80,
  parameter int height   = 8,
  parameter int width_b  = 7,
  parameter int height_b = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [width_b-1:0]    write_w,
  input  logic [height_b-1:0]   write_h,
  input  logic [71:0]           data_in,
  input  logic [8:0]            en_in,
  input  logic [9*width_b-1:0]  readi_w,
  input  logic [9*height_b-1:0] readi_h,
  input  logic [8:0]            en_read,
  input  logic                  en_bias,
  input  logic [2:0]            step,
  input  logic                  en_pe,
  input  logic [height_b-1:0]   bound_level,
  input  logic [2:0]            step_p,
  input  logic                  en_relu,
  input  logic                  en_mp,
  output logic [8*height-1:0]   out,
  output logic [height-1:0]     out_en
);
  localparam int taps  = 9;
  localparam int cols  = width + 2;
  localparam int acc_w = 21;
  localparam logic signed [acc_w-1:0] sat_hi = acc_w'(127);
  localparam logic signed [acc_w-1:0] sat_lo = -acc_w'(128);

  // Command controls that travel down the pipeline alongside the data.
  typedef struct packed {
    logic                pe;
    logic [2:0]          step_p;
    logic                relu;
    logic [height_b-1:0] bound;
  } ctrl_t;

  logic [7:0]                buffer [height][cols];
  logic [width_b:0]          wr_col [taps];
  logic [width_b-1:0]        rd_col [taps];
  logic [height_b-1:0]       rd_row [taps];
  logic [7:0]                x_d    [taps];
  logic [2:0]                blk;
  logic [width_b-1:0]        w_base;
  logic [7:0]                w_d    [height][taps];
  logic [15:0]               bias_d [height];

  logic [7:0]                x_q    [taps];
  logic [7:0]                w_q    [height][taps];
  logic [15:0]               bias_q [height];
  ctrl_t                     ctrl1, ctrl2;

  logic signed [acc_w-1:0]   acc_d  [height];
  logic signed [acc_w-1:0]   acc_q  [height];

  logic signed [acc_w-1:0]   shifted [height];
  logic signed [7:0]         sat     [height];
  logic signed [7:0]         pooled  [height];
  logic [height-1:0]         keep;
  logic [8*height-1:0]       out_d;
  logic [height-1:0]         out_en_d;

  // Address decode for the write port and the read lanes.
  // NOTE: every always_comb output gets a default before any condition, so no path can infer a latch.
  always_comb begin
    for (int k = 0; k < taps; k++) begin
      wr_col[k] = {1'b0, write_w} + (width_b+1)'(k);
      rd_col[k] = readi_w[taps*width_b-1-width_b*k -: width_b];
      rd_row[k] = readi_h[taps*height_b-1-height_b*k -: height_b];
    end
  end

  // Buffer write port; lanes that land beyond the last column are dropped.
  // NOTE: the buffer is deliberately left unreset -- its contents must survive a pipeline reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < taps; k++) begin
      if (en_in[taps-1-k] && (wr_col[k] < (width_b+1)'(cols))) begin
        buffer[write_h][wr_col[k][width_b-1:0]] <= data_in[8*taps-1-8*k -: 8];
      end
    end
  end

  // Read-stage operands: shared activations plus each row's weights and bias.
  always_comb begin
    blk    = (step > 3'd5) ? 3'd5 : step;
    w_base = width_b'(width - taps) - width_b'(blk) * width_b'(taps);
    for (int k = 0; k < taps; k++) begin
      x_d[k] = '0;
      if (en_read[taps-1-k] && (rd_col[k] < width_b'(cols))) begin
        x_d[k] = buffer[rd_row[k]][rd_col[k]];
      end
    end
    for (int r = 0; r < height; r++) begin
      for (int k = 0; k < taps; k++) begin
        w_d[r][k] = buffer[r][w_base + width_b'(k)];
      end
      bias_d[r] = en_bias ? {buffer[r][width], buffer[r][width+1]} : 16'h0000;
    end
  end

  // Stage 1: read register; weights are captured here so later writes cannot disturb an issued compute.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < taps; k++) x_q[k] <= '0;
      for (int r = 0; r < height; r++) begin
        bias_q[r] <= '0;
        for (int k = 0; k < taps; k++) w_q[r][k] <= '0;
      end
      ctrl1 <= '0;
    end else begin
      x_q    <= x_d;
      w_q    <= w_d;
      bias_q <= bias_d;
      ctrl1  <= '{pe: en_pe, step_p: step_p, relu: en_relu, bound: bound_level};
    end
  end

  // Per-row 9-tap MAC: unsigned activations times signed weights plus signed bias.
  always_comb begin
    for (int r = 0; r < height; r++) begin
      acc_d[r] = acc_w'($signed(bias_q[r]));
      for (int k = 0; k < taps; k++) begin
        acc_d[r] = acc_d[r]
                 + acc_w'($signed({1'b0, x_q[k]})) * acc_w'($signed(w_q[r][k]));
      end
    end
  end

  // Stage 2: accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < height; r++) acc_q[r] <= '0;
      ctrl2 <= '0;
    end else begin
      acc_q <= acc_d;
      ctrl2 <= ctrl1;
    end
  end

`ifdef NPU_SIMPLE_MAXPOOL_EN
  logic mp1, mp2;

  // Pool enable follows the command through both pipeline stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mp1 <= 1'b0;
      mp2 <= 1'b0;
    end else begin
      mp1 <= en_mp;
      mp2 <= mp1;
    end
  end
`else
  // en_mp has no effect in this build.
  logic unused_mp;
  assign unused_mp = en_mp;
`endif

  // Post stage: shift, saturate, ReLU, optional pooling, then row masking.
  always_comb begin
    out_d    = '0;
    out_en_d = '0;
    keep     = '1;
    for (int r = 0; r < height; r++) begin
      shifted[r] = acc_q[r] >>> ctrl2.step_p;
      if (shifted[r] > sat_hi)      sat[r] = 8'sd127;
      else if (shifted[r] < sat_lo) sat[r] = -8'sd128;
      else                          sat[r] = shifted[r][7:0];
      if (ctrl2.relu && sat[r][7])  sat[r] = 8'sd0;
      pooled[r] = sat[r];
    end
`ifdef NPU_SIMPLE_MAXPOOL_EN
    if (mp2) begin
      for (int i = 0; i < height/2; i++) begin
        pooled[2*i]   = (sat[2*i] > sat[2*i+1]) ? sat[2*i] : sat[2*i+1];
        pooled[2*i+1] = pooled[2*i];
        keep[2*i+1]   = 1'b0;
      end
    end
`endif
    for (int r = 0; r < height; r++) begin
      if (height_b'(r) <= ctrl2.bound) begin
        out_d[8*height-1-8*r -: 8] = pooled[r];
        out_en_d[height-1-r]       = keep[r];
      end
    end
  end

  // Output register: loads on an issued compute, otherwise only drops the valids.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out    <= '0;
      out_en <= '0;
    end else if (ctrl2.pe) begin
      out    <= out_d;
      out_en <= out_en_d;
    end else begin
      out_en <= '0;
    end
  end
endmodule

// File: tb/tb_npu_simple_core.sv
// Testbench for npu_simple_core: directed vector table, hand-written
// pipeline/reset sequences and a randomized run against a behavioural model.
module tb_npu_simple_core;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  write_w;
  logic [2:0]  write_h;
  logic [71:0] data_in;
  logic [8:0]  en_in;
  logic [62:0] readi_w;
  logic [26:0] readi_h;
  logic [8:0]  en_read;
  logic        en_bias;
  logic [2:0]  step;
  logic        en_pe;
  logic [2:0]  bound_level;
  logic [2:0]  step_p;
  logic        en_relu;
  logic        en_mp;
  logic [63:0] out;
  logic [7:0]  out_en;

  npu_simple_core dut (
    .clk(clk), .reset(reset), .write_w(write_w), .write_h(write_h),
    .data_in(data_in), .en_in(en_in), .readi_w(readi_w), .readi_h(readi_h),
    .en_read(en_read), .en_bias(en_bias), .step(step), .en_pe(en_pe),
    .bound_level(bound_level), .step_p(step_p), .en_relu(en_relu),
    .en_mp(en_mp), .out(out), .out_en(out_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [62:0] rw;
    logic [26:0] rh;
    logic [8:0]  er;
    logic        eb;
    logic [2:0]  step;
    logic        pe;
    logic [2:0]  bl;
    logic [2:0]  sp;
    logic        relu;
    logic        mp;
  } cmd_t;

  typedef struct {
    string       name;
    logic [7:0]  act;
    logic [7:0]  wt;
    logic [15:0] bias;
    logic        eb;
    logic [2:0]  step;
    int          wblk;
    logic [2:0]  sp;
    logic [2:0]  bl;
    logic        relu;
    logic        mp;
    logic [63:0] exp_out;
    logic [7:0]  exp_en;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] mem [8][82];
  bit         pool_on;
  cmd_t       idle_cmd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input cmd_t c);
    readi_w = c.rw; readi_h = c.rh; en_read = c.er; en_bias = c.eb;
    step = c.step; en_pe = c.pe; bound_level = c.bl; step_p = c.sp;
    en_relu = c.relu; en_mp = c.mp;
  endtask

  task automatic model_write(input int h, input int w, input logic [71:0] d, input logic [8:0] en);
    for (int k = 0; k < 9; k++)
      if (en[8-k] && (w + k) <= 81) mem[h][w+k] = d[71-8*k -: 8];
  endtask

  // One write cycle; the model tracks what the buffer should hold.
  task automatic write_cycle(input int h, input int w, input logic [71:0] d, input logic [8:0] en);
    @(negedge clk);
    write_h = 3'(h); write_w = 7'(w); data_in = d; en_in = en;
    model_write(h, w, d, en);
    @(posedge clk); #1;
    en_in = '0;
  endtask

  task automatic fill(input int h, input int c0, input int c1, input logic [7:0] val);
    logic [8:0] en;
    for (int c = c0; c <= c1; c += 9) begin
      en = '0;
      for (int k = 0; k < 9; k++) if (c + k <= c1) en[8-k] = 1'b1;
      write_cycle(h, c, {9{val}}, en);
    end
  endtask

  function automatic cmd_t row0_cmd(input logic eb, input logic [2:0] stp, input logic [2:0] sp,
                                    input logic [2:0] bl, input logic relu, input logic mp);
    cmd_t c;
    c = '0;
    for (int k = 0; k < 9; k++) c.rw[62-7*k -: 7] = 7'(k);
    c.er = '1; c.eb = eb; c.step = stp; c.pe = 1'b1; c.bl = bl; c.sp = sp;
    c.relu = relu; c.mp = mp;
    return c;
  endfunction

  // Drive one command, then idle; result is visible after the 3rd edge.
  task automatic run_single(input cmd_t c);
    @(negedge clk); drive_cmd(c);
    @(negedge clk); drive_cmd(idle_cmd);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Behavioural model: integer arithmetic straight from the block's rules.
  task automatic model_cmd(input cmd_t c, output logic [63:0] o, output logic [7:0] e);
    int x [9];
    int v [8];
    int acc, col, row, base, m;
    for (int k = 0; k < 9; k++) begin
      col = int'(c.rw[62-7*k -: 7]);
      row = int'(c.rh[26-3*k -: 3]);
      x[k] = 0;
      if (c.er[8-k] && col <= 81) x[k] = int'(mem[row][col]);
    end
    base = 71 - 9 * ((c.step > 5) ? 5 : int'(c.step));
    for (int r = 0; r < 8; r++) begin
      acc = c.eb ? int'($signed({mem[r][80], mem[r][81]})) : 0;
      for (int k = 0; k < 9; k++) acc += x[k] * int'($signed(mem[r][base+k]));
      v[r] = acc >>> c.sp;
      if (v[r] > 127) v[r] = 127;
      if (v[r] < -128) v[r] = -128;
      if (c.relu && v[r] < 0) v[r] = 0;
    end
    if (pool_on && c.mp)
      for (int i = 0; i < 4; i++) begin
        m = (v[2*i] > v[2*i+1]) ? v[2*i] : v[2*i+1];
        v[2*i] = m; v[2*i+1] = m;
      end
    o = '0; e = '0;
    for (int r = 0; r < 8; r++)
      if (r <= int'(c.bl)) begin
        o[63-8*r -: 8] = 8'(v[r]);
        e[7-r] = !(pool_on && c.mp && (r % 2 == 1));
      end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c = '0;
    for (int k = 0; k < 9; k++) begin
      c.rw[62-7*k -: 7] = 7'($urandom_range(0, 95));
      c.rh[26-3*k -: 3] = 3'($urandom);
    end
    c.er = 9'($urandom); c.eb = 1'($urandom); c.step = 3'($urandom);
    c.pe = ($urandom % 4) != 0; c.bl = 3'($urandom); c.sp = 3'($urandom);
    c.relu = 1'($urandom); c.mp = 1'($urandom);
    return c;
  endfunction

  function automatic vec_t mk(input string name, input logic [7:0] act, input logic [7:0] wt,
                              input logic [15:0] bias, input logic eb, input logic [2:0] stp,
                              input int wblk, input logic [2:0] sp, input logic [2:0] bl,
                              input logic relu, input logic mp, input logic [63:0] eo,
                              input logic [7:0] ee);
    vec_t v;
    v.name = name; v.act = act; v.wt = wt; v.bias = bias; v.eb = eb; v.step = stp;
    v.wblk = wblk; v.sp = sp; v.bl = bl; v.relu = relu; v.mp = mp;
    v.exp_out = eo; v.exp_en = ee;
    return v;
  endfunction

  task automatic clear_all();
    for (int r = 0; r < 8; r++) fill(r, 0, 81, 8'h00);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  vec_t        vecs [$];
  logic [63:0] q_out [$];
  logic [7:0]  q_en  [$];
  logic [63:0] eo, last_out, pool_exp, pool4_exp;
  logic [7:0]  ee, pool_en, pool4_en;
  logic [95:0] rnd;
  cmd_t        c;

  initial begin
`ifdef NPU_SIMPLE_MAXPOOL_EN
    pool_on   = 1'b1;
    pool_exp  = 64'h09090303_07076464; pool_en  = 8'hAA;
    pool4_exp = 64'h09090303_07000000; pool4_en = 8'hA8;
`else
    pool_on   = 1'b0;
    pool_exp  = 64'h05090301_FC076402; pool_en  = 8'hFF;
    pool4_exp = 64'h05090301_FC000000; pool4_en = 8'hF8;
`endif
    reset = 1'b0; write_w = '0; write_h = '0; data_in = '0; en_in = '0;
    drive_cmd(idle_cmd);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 64'h0);
    check("reset_en", {56'h0, out_en}, 64'h0);
    @(negedge clk); reset = 1'b1;

    // name, act, wt, bias, eb, step, wblk, sp, bl, relu, mp, exp_out, exp_en
    vecs.push_back(mk("sum_bias",   8'h02, 8'h01, 16'h0010, 1, 0, 0, 0, 7, 0, 0, {8{8'h22}}, 8'hFF));
    vecs.push_back(mk("sat_pos",    8'hFF, 8'h7F, 16'h0000, 0, 0, 0, 0, 7, 0, 0, {8{8'h7F}}, 8'hFF));
    vecs.push_back(mk("sat_neg",    8'hFF, 8'h80, 16'h0000, 0, 0, 0, 0, 7, 0, 0, {8{8'h80}}, 8'hFF));
    vecs.push_back(mk("shift7_neg", 8'hFF, 8'h80, 16'h0000, 0, 0, 0, 7, 7, 0, 0, {8{8'h80}}, 8'hFF));
    vecs.push_back(mk("shift2",     8'h02, 8'h01, 16'h0010, 1, 0, 0, 2, 7, 0, 0, {8{8'h08}}, 8'hFF));
    vecs.push_back(mk("relu_off",   8'h0A, 8'hFF, 16'h0000, 0, 0, 0, 0, 7, 0, 0, {8{8'hA6}}, 8'hFF));
    vecs.push_back(mk("relu_on",    8'h0A, 8'hFF, 16'h0000, 0, 0, 0, 0, 7, 1, 0, {8{8'h00}}, 8'hFF));
    vecs.push_back(mk("bias_neg",   8'h00, 8'h01, 16'hFF00, 1, 0, 0, 1, 7, 0, 0, {8{8'h80}}, 8'hFF));
    vecs.push_back(mk("bound3",     8'h02, 8'h01, 16'h0010, 1, 0, 0, 0, 3, 0, 0, 64'h22222222_00000000, 8'hF0));
    vecs.push_back(mk("bound0",     8'h02, 8'h01, 16'h0010, 1, 0, 0, 0, 0, 0, 0, 64'h22000000_00000000, 8'h80));
    vecs.push_back(mk("step1",      8'h02, 8'h01, 16'h0010, 1, 1, 1, 0, 7, 0, 0, {8{8'h22}}, 8'hFF));
    vecs.push_back(mk("step6",      8'h02, 8'h01, 16'h0010, 1, 6, 5, 0, 7, 0, 0, {8{8'h22}}, 8'hFF));
    vecs.push_back(mk("step7",      8'h02, 8'h01, 16'h0010, 1, 7, 5, 0, 7, 0, 0, {8{8'h22}}, 8'hFF));
    vecs.push_back(mk("pool_flat",  8'h02, 8'h01, 16'h0010, 1, 0, 0, 0, 7, 0, 1, {8{8'h22}},
                      pool_on ? 8'hAA : 8'hFF));

    foreach (vecs[i]) begin
      clear_all();
      for (int r = 0; r < 8; r++) begin
        fill(r, 0, 8, vecs[i].act);
        fill(r, 71 - 9 * vecs[i].wblk, 79 - 9 * vecs[i].wblk, vecs[i].wt);
        write_cycle(r, 80, {vecs[i].bias, 56'h0}, 9'b1_1000_0000);
      end
      run_single(row0_cmd(vecs[i].eb, vecs[i].step, vecs[i].sp, vecs[i].bl, vecs[i].relu, vecs[i].mp));
      check({vecs[i].name, "_out"}, out, vecs[i].exp_out);
      check({vecs[i].name, "_en"}, {56'h0, out_en}, {56'h0, vecs[i].exp_en});
    end

    // Distinct per-row values via bias only: 5, 9, 3, 1, -4, 7, 100, 2.
    clear_all();
    write_cycle(0, 80, {16'h0005, 56'h0}, 9'b1_1000_0000);
    write_cycle(1, 80, {16'h0009, 56'h0}, 9'b1_1000_0000);
    write_cycle(2, 80, {16'h0003, 56'h0}, 9'b1_1000_0000);
    write_cycle(3, 80, {16'h0001, 56'h0}, 9'b1_1000_0000);
    write_cycle(4, 80, {16'hFFFC, 56'h0}, 9'b1_1000_0000);
    write_cycle(5, 80, {16'h0007, 56'h0}, 9'b1_1000_0000);
    write_cycle(6, 80, {16'h0064, 56'h0}, 9'b1_1000_0000);
    write_cycle(7, 80, {16'h0002, 56'h0}, 9'b1_1000_0000);
    run_single(row0_cmd(1, 0, 0, 7, 0, 1));
    check("pool_out", out, pool_exp);
    check("pool_en", {56'h0, out_en}, {56'h0, pool_en});
    run_single(row0_cmd(1, 0, 0, 4, 0, 1));
    check("pool_mask_out", out, pool4_exp);
    check("pool_mask_en", {56'h0, out_en}, {56'h0, pool4_en});
    @(posedge clk); #1;
    check("hold_out", out, pool4_exp);
    check("hold_en", {56'h0, out_en}, 64'h0);

    // Reset mid-compute: outputs clear at once and the dropped command never appears.
    @(negedge clk); drive_cmd(row0_cmd(1, 0, 0, 7, 0, 1));
    @(posedge clk); #1;
    @(negedge clk); drive_cmd(idle_cmd); reset = 1'b0;
    #1;
    check("reset_async_out", out, 64'h0);
    check("reset_async_en", {56'h0, out_en}, 64'h0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_reset_out", out, 64'h0);
      check("post_reset_en", {56'h0, out_en}, 64'h0);
    end
    run_single(row0_cmd(1, 0, 0, 7, 0, 1));
    check("buffer_kept_out", out, pool_exp);

    // Write and read of the same cell in one cycle returns old data; back-to-back commands.
    clear_all();
    for (int r = 0; r < 8; r++) fill(r, 71, 79, 8'h01);
    fill(0, 0, 0, 8'h01);
    c = row0_cmd(0, 0, 0, 7, 0, 0);
    c.er = 9'b1_0000_0000;
    @(negedge clk);
    drive_cmd(c);
    write_h = 3'd0; write_w = 7'd0; data_in = {8'h05, 64'h0}; en_in = 9'b1_0000_0000;
    model_write(0, 0, {8'h05, 64'h0}, 9'b1_0000_0000);
    @(negedge clk); en_in = '0;
    @(negedge clk); drive_cmd(idle_cmd);
    @(posedge clk); #1;
    check("rw_old_out", out, {8{8'h01}});
    check("rw_old_en", {56'h0, out_en}, 64'hFF);
    @(posedge clk); #1;
    check("rw_new_out", out, {8{8'h05}});
    check("rw_new_en", {56'h0, out_en}, 64'hFF);

    // Randomized back-to-back traffic with overlapping writes.
    pulse_reset();
    last_out = '0;
    for (int r = 0; r < 8; r++)
      for (int col = 0; col <= 81; col += 9) begin
        rnd = {$urandom, $urandom, $urandom};
        write_cycle(r, col, rnd[71:0], 9'h1FF);
      end
    for (int i = 0; i < 403; i++) begin
      @(negedge clk);
      c = (i < 400) ? rand_cmd() : idle_cmd;
      model_cmd(c, eo, ee);
      if (c.pe) last_out = eo;
      else begin eo = last_out; ee = '0; end
      q_out.push_back(eo); q_en.push_back(ee);
      drive_cmd(c);
      en_in = '0;
      if (i < 400 && ($urandom % 2) == 1) begin
        rnd = {$urandom, $urandom, $urandom};
        write_h = 3'($urandom); write_w = 7'($urandom_range(0, 90));
        data_in = rnd[71:0]; en_in = 9'($urandom);
        model_write(int'(write_h), int'(write_w), data_in, en_in);
      end
      @(posedge clk); #1;
      if (q_out.size() == 3) begin
        eo = q_out.pop_front(); ee = q_en.pop_front();
        check("rand_out", out, eo);
        check("rand_en", {56'h0, out_en}, {56'h0, ee});
      end
    end
    en_in = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
